// File: rtl/pipe_hazard_ctl.sv
// Control and scheduling unit for the 5-stage MIPS-subset pipeline: ID decode,
// stage control registers, load-use stall, branch/jump flush and a debug run/step sequencer.
module pipe_hazard_ctl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [31:0]      ifid_ins,
  input  logic             beq_eq,
  output logic             pipe_en,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic [1:0]       npc_sel,
  output logic             id_rd,
  output logic             ex_alus,
  output logic [2:0]       ex_aluo,
  output logic             mem_we,
  output logic             wb_rw,
  output logic             wb_m2r,
  output logic             stall,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;

  typedef enum logic [1:0] {
    SEQ_HALT = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_STEP = 2'd2
  } seq_e;

  typedef struct packed {
    logic       valid;
    logic       rw;
    logic       rd;
    logic       alus;
    logic [2:0] aluo;
    logic       m2r;
    logic       mw;
    logic       br;
    logic       jmp;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] wa;
  } dec_t;

  typedef struct packed {
    logic       valid;
    logic       rw;
    logic       alus;
    logic [2:0] aluo;
    logic       m2r;
    logic       mw;
    logic [4:0] wa;
  } idex_t;

  typedef struct packed {
    logic valid;
    logic rw;
    logic m2r;
    logic mw;
  } exmem_t;

  typedef struct packed {
    logic valid;
    logic rw;
    logic m2r;
  } memwb_t;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op    = ifid_ins[31:26];
  assign rs    = ifid_ins[25:21];
  assign rt    = ifid_ins[20:16];
  assign rd    = ifid_ins[15:11];
  assign funct = ifid_ins[5:0];

  seq_e              state_q, state_d;
  dec_t              dec;
  idex_t             idex_q, idex_d;
  exmem_t            exmem_q, exmem_d;
  memwb_t            memwb_q, memwb_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              load_use;

  // ID decode; unrecognised words (including all-zero) decode as a bubble.
  always_comb begin
    dec = '0;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_ADD) begin
          dec.valid  = 1'b1;
          dec.rw     = 1'b1;
          dec.rd     = 1'b1;
          dec.use_rs = 1'b1;
          dec.use_rt = 1'b1;
        end
      end
      OP_ADDI: begin
        dec.valid  = 1'b1;
        dec.rw     = 1'b1;
        dec.alus   = 1'b1;
        dec.use_rs = 1'b1;
      end
      OP_LW: begin
        dec.valid  = 1'b1;
        dec.rw     = 1'b1;
        dec.alus   = 1'b1;
        dec.m2r    = 1'b1;
        dec.use_rs = 1'b1;
      end
      OP_SW: begin
        dec.valid  = 1'b1;
        dec.alus   = 1'b1;
        dec.mw     = 1'b1;
        dec.use_rs = 1'b1;
        dec.use_rt = 1'b1;
      end
      OP_BEQ: begin
        dec.valid  = 1'b1;
        dec.br     = 1'b1;
        dec.use_rs = 1'b1;
        dec.use_rt = 1'b1;
      end
      OP_J: begin
        dec.valid = 1'b1;
        dec.jmp   = 1'b1;
      end
      default: ;
    endcase
    if (dec.valid) dec.wa = dec.rd ? rd : rt;
    if (dec.wa == 5'd0) dec.rw = 1'b0;
  end

  // Only a load in EX can create a hazard the bypass network cannot cover.
  assign load_use = idex_q.valid && idex_q.m2r && (idex_q.wa != 5'd0) &&
                    ((dec.use_rs && (rs == idex_q.wa)) ||
                     (dec.use_rt && (rt == idex_q.wa)));

  always_comb begin
    idex_d = '0;
    if (!load_use) begin
      idex_d.valid = dec.valid;
      idex_d.rw    = dec.rw;
      idex_d.alus  = dec.alus;
      idex_d.aluo  = dec.aluo;
      idex_d.m2r   = dec.m2r;
      idex_d.mw    = dec.mw;
      idex_d.wa    = dec.wa;
    end
    exmem_d   = '{valid: idex_q.valid, rw: idex_q.rw, m2r: idex_q.m2r, mw: idex_q.mw};
    memwb_d   = '{valid: exmem_q.valid, rw: exmem_q.rw, m2r: exmem_q.m2r};
    retired_d = memwb_q.valid ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q    <= '0;
      exmem_q   <= '0;
      memwb_q   <= '0;
      retired_q <= '0;
    end else if (pipe_en) begin
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
      retired_q <= retired_d;
    end
  end

  // Sequencer: state register, next-state logic, output decode.
  always_ff @(posedge clk) begin
    if (rst) state_q <= SEQ_HALT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_HALT: begin
        if (run)       state_d = SEQ_RUN;
        else if (step) state_d = SEQ_STEP;
      end
      SEQ_RUN:  if (!run) state_d = SEQ_HALT;
      SEQ_STEP: state_d = SEQ_HALT;
      default:  state_d = SEQ_HALT;
    endcase
  end

  always_comb begin
    pipe_en = 1'b0;
    halted  = 1'b0;
    case (state_q)
      SEQ_RUN, SEQ_STEP: pipe_en = 1'b1;
      default:           halted  = 1'b1;
    endcase
  end

  // Redirects are suppressed while frozen so the PC cannot move under a halt.
  always_comb begin
    npc_sel    = 2'd0;
    ifid_flush = 1'b0;
    if (pipe_en) begin
      if (dec.jmp) begin
        npc_sel    = 2'd2;
        ifid_flush = 1'b1;
      end else if (dec.br && beq_eq && !load_use) begin
        npc_sel    = 2'd1;
        ifid_flush = 1'b1;
      end
    end
  end

  assign pc_we   = pipe_en && !load_use;
  assign ifid_we = pipe_en && !load_use;
  assign stall   = load_use;
  assign id_rd   = dec.rd;
  assign ex_alus = idex_q.alus;
  assign ex_aluo = idex_q.aluo;
  assign mem_we  = pipe_en && exmem_q.mw;
  assign wb_rw   = pipe_en && memwb_q.rw;
  assign wb_m2r  = memwb_q.m2r;
  assign retired = retired_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl: an instruction-word pipeline model with an emulated
// IF/ID register, directed scenarios followed by a randomized run/step/reset phase.
module tb_pipe_hazard_ctl;
  localparam int CNT_W = 32;

  localparam int K_NOP = 0, K_ADD = 1, K_ADDI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5, K_J = 6;
  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst, run, step, beq_eq;
  logic [31:0]      ifid_ins;
  logic             pipe_en, pc_we, ifid_we, ifid_flush;
  logic [1:0]       npc_sel;
  logic             id_rd, ex_alus, mem_we, wb_rw, wb_m2r, stall, halted;
  logic [2:0]       ex_aluo;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  pipe_hazard_ctl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .ifid_ins(ifid_ins), .beq_eq(beq_eq),
    .pipe_en(pipe_en), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .npc_sel(npc_sel), .id_rd(id_rd), .ex_alus(ex_alus), .ex_aluo(ex_aluo),
    .mem_we(mem_we), .wb_rw(wb_rw), .wb_m2r(wb_m2r), .stall(stall),
    .halted(halted), .retired(retired)
  );

  // ---------------- reference model state ----------------
  int               n_vec = 0;
  int               n_err = 0;
  int               mode;
  logic [31:0]      ifid_w, ex_w, mem_w, wb_w;
  logic [CNT_W-1:0] ret_m;
  logic [31:0]      exp_q[$];
  bit               rand_fetch;
  int               stall_seen, mem_we_seen, pe_seen;

  function automatic int kind(input logic [31:0] w);
    case (w[31:26])
      6'h00:   return (w[5:0] == 6'h20) ? K_ADD : K_NOP;
      6'h08:   return K_ADDI;
      6'h23:   return K_LW;
      6'h2b:   return K_SW;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
      default: return K_NOP;
    endcase
  endfunction

  function automatic int dest(input logic [31:0] w);
    int k = kind(w);
    if (k == K_ADD) return int'(w[15:11]);
    if (k == K_ADDI || k == K_LW) return int'(w[20:16]);
    return 0;
  endfunction

  function automatic bit writes(input logic [31:0] w);
    int k = kind(w);
    return (k == K_ADD || k == K_ADDI || k == K_LW) && dest(w) != 0;
  endfunction

  function automatic bit reads_rs(input logic [31:0] w);
    int k = kind(w);
    return k == K_ADD || k == K_ADDI || k == K_LW || k == K_SW || k == K_BEQ;
  endfunction

  function automatic bit reads_rt(input logic [31:0] w);
    int k = kind(w);
    return k == K_ADD || k == K_SW || k == K_BEQ;
  endfunction

  function automatic logic [31:0] enc_r(input int d, input int s, input int t);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int s, input int t, input int imm);
    return {op, 5'(s), 5'(t), 16'(imm)};
  endfunction

  function automatic logic [31:0] rnd_ins();
    int a = $urandom_range(0, 3);
    int b = $urandom_range(0, 3);
    int c = $urandom_range(0, 3);
    case ($urandom_range(0, 7))
      0:       return enc_r(a, b, c);
      1:       return enc_i(6'h08, b, a, $urandom_range(0, 255));
      2, 3:    return enc_i(6'h23, b, a, 0);
      4:       return enc_i(6'h2b, b, a, 4);
      5:       return enc_i(6'h04, b, a, 2);
      6:       return {6'h02, 26'h10};
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] next_word();
    if (exp_q.size() != 0) return exp_q.pop_front();
    if (rand_fetch) return rnd_ins();
    return 32'h0;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cyc(input bit r_in, input bit run_in, input bit step_in, input bit eq_in);
    bit          pe, st, fl;
    int          k, ek;
    logic [1:0]  npc;
    logic [31:0] drop;
    rst = r_in; run = run_in; step = step_in; beq_eq = eq_in; ifid_ins = ifid_w;
    #1;
    pe = (mode != M_HALT);
    k  = kind(ifid_w);
    ek = kind(ex_w);
    st = (ek == K_LW) && dest(ex_w) != 0 &&
         ((reads_rs(ifid_w) && int'(ifid_w[25:21]) == dest(ex_w)) ||
          (reads_rt(ifid_w) && int'(ifid_w[20:16]) == dest(ex_w)));
    if (!pe)                             npc = 2'd0;
    else if (k == K_J)                   npc = 2'd2;
    else if (k == K_BEQ && eq_in && !st) npc = 2'd1;
    else                                 npc = 2'd0;
    fl = (npc != 2'd0);

    chk("pipe_en",    pipe_en,    pe);
    chk("pc_we",      pc_we,      pe && !st);
    chk("ifid_we",    ifid_we,    pe && !st);
    chk("ifid_flush", ifid_flush, fl);
    chk("npc_sel",    npc_sel,    npc);
    chk("id_rd",      id_rd,      k == K_ADD);
    chk("ex_alus",    ex_alus,    ek == K_ADDI || ek == K_LW || ek == K_SW);
    chk("ex_aluo",    ex_aluo,    3'd0);
    chk("mem_we",     mem_we,     pe && kind(mem_w) == K_SW);
    chk("wb_rw",      wb_rw,      pe && writes(wb_w));
    chk("wb_m2r",     wb_m2r,     kind(wb_w) == K_LW);
    chk("stall",      stall,      st);
    chk("halted",     halted,     !pe);
    chk("retired",    retired,    ret_m);
    if (stall === 1'b1)   stall_seen++;
    if (mem_we === 1'b1)  mem_we_seen++;
    if (pipe_en === 1'b1) pe_seen++;

    @(posedge clk);
    if (r_in) begin
      mode = M_HALT; ifid_w = 32'h0; ex_w = 32'h0; mem_w = 32'h0; wb_w = 32'h0; ret_m = '0;
    end else begin
      if (pe) begin
        if (kind(wb_w) != K_NOP) ret_m = ret_m + 1'b1;
        wb_w  = mem_w;
        mem_w = ex_w;
        ex_w  = st ? 32'h0 : ifid_w;
        if (fl) begin
          drop   = next_word();   // word fetched behind the transfer is squashed
          ifid_w = 32'h0;
        end else if (!st) begin
          ifid_w = next_word();
        end
      end
      case (mode)
        M_HALT:  if (run_in) mode = M_RUN; else if (step_in) mode = M_STEP;
        M_RUN:   if (!run_in) mode = M_HALT;
        default: mode = M_HALT;
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    exp_q.delete();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    stall_seen = 0; mem_we_seen = 0; pe_seen = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit run_lvl;
    rand_fetch = 1'b0;
    rst = 1'b1; run = 1'b0; step = 1'b0; beq_eq = 1'b0; ifid_ins = 32'h0;
    @(posedge clk); #1;
    mode = M_HALT; ifid_w = 32'h0; ex_w = 32'h0; mem_w = 32'h0; wb_w = 32'h0; ret_m = '0;
    stall_seen = 0; mem_we_seen = 0; pe_seen = 0;

    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_retired", retired, 0);
    chk("reset_halted", halted, 1);

    // addi $1,$0,5 ; add $2,$1,$1
    do_reset();
    exp_q.push_back(enc_i(6'h08, 0, 1, 5));
    exp_q.push_back(enc_r(2, 1, 1));
    repeat (12) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("s1_retired", retired, 2);
    chk("s1_stalls", stall_seen, 0);

    // lw $3,0($0) ; add $4,$3,$3
    do_reset();
    exp_q.push_back(enc_i(6'h23, 0, 3, 0));
    exp_q.push_back(enc_r(4, 3, 3));
    repeat (12) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("s2_stalls", stall_seen, 1);
    chk("s2_retired", retired, 2);

    // lw $3 ; beq $3,$0,+2 (taken) ; squashed word ; target
    do_reset();
    exp_q.push_back(enc_i(6'h23, 0, 3, 0));
    exp_q.push_back(enc_i(6'h04, 3, 0, 2));
    exp_q.push_back(enc_i(6'h08, 0, 7, 1));
    exp_q.push_back(enc_i(6'h08, 0, 6, 2));
    repeat (14) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("s3_stalls", stall_seen, 1);
    chk("s3_retired", retired, 3);

    // j 0x10 ; squashed word ; target
    do_reset();
    exp_q.push_back({6'h02, 26'h10});
    exp_q.push_back(enc_i(6'h08, 0, 1, 1));
    exp_q.push_back(enc_i(6'h08, 0, 2, 2));
    repeat (12) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("s4_retired", retired, 2);

    // lw $0,0($0) ; add $5,$0,$0
    do_reset();
    exp_q.push_back(enc_i(6'h23, 0, 0, 0));
    exp_q.push_back(enc_r(5, 0, 0));
    repeat (12) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("s5_stalls", stall_seen, 0);
    chk("s5_retired", retired, 2);

    // Halt with a store parked in EX/MEM, then a single step
    do_reset();
    exp_q.push_back(enc_i(6'h2b, 0, 1, 0));
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    mem_we_seen = 0; pe_seen = 0;
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s6_hold_mem_we", mem_we_seen, 0);
    chk("s6_hold_pe", pe_seen, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s6_step_mem_we", mem_we_seen, 1);
    chk("s6_step_pe", pe_seen, 1);
    chk("s6_halted", halted, 1);

    // Randomized run/step/reset with random instruction stream
    do_reset();
    rand_fetch = 1'b1;
    run_lvl = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) run_lvl = ~run_lvl;
      cyc($urandom_range(0, 63) == 0, run_lvl, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctl.md
Name: pipe_hazard_ctl

Overview:
- Central control/scheduling unit for the 5-stage pipelined MIPS-subset CPU (add, addi, lw, sw, beq, j).
- Decodes the ID-stage instruction, carries control bits down the ID/EX, EX/MEM and MEM/WB stages, and detects load-use hazards (stall) and taken control transfers (flush).
- Provides a run/halt/single-step sequencer for the debug unit and counts retired instructions.
- The datapath keeps its pipeline registers, bypass muxes and branch comparator; this block only drives their enables and selects.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; 1 = free-run requested
- step  in  1  single-cycle pulse; advance pipeline one cycle while halted
- ifid_ins  in  32  instruction in IF/ID register
- beq_eq  in  1  bypassed rs==rt comparison from ID stage
- pipe_en  out  1  global advance enable for pc and all pipeline registers
- pc_we  out  1  PC load enable (pipe_en and not stall)
- ifid_we  out  1  IF/ID load enable (pipe_en and not stall)
- ifid_flush  out  1  IF/ID loads nop (0x00000000) instead of fetched word
- npc_sel  out  2  0 = pc+4, 1 = branch target, 2 = jump target
- id_rd  out  1  wa select: 1 = rd, 0 = rt
- ex_alus  out  1  ALU b select: 1 = imm
- ex_aluo  out  3  ALU op (0 = add)
- mem_we  out  1  data memory write enable
- wb_rw  out  1  register file write enable
- wb_m2r  out  1  write-back select: 1 = memory data
- stall  out  1  load-use stall this cycle
- halted  out  1  sequencer in HALT
- retired  out  CNT_W  count of non-bubble instructions completing WB

Behaviour:
- Decode (ID, combinational on ifid_ins):
  - R-type op=000000 with funct=100000 is add: rw, rd=1, aluo=0.
  - addi 001000: rw, alus.
  - lw 100011: rw, alus, m2r.
  - sw 101011: alus, mw.
  - beq 000100: branch.
  - j 000010: jump.
  - Any other word, including 0, is a bubble: all bits 0, valid=0.
  - A write to register 0 clears rw.
- Destination: wa = rd if id_rd, else rt. Stored with the stage control bits.
- Load-use stall: stall=1 when ID/EX holds a valid lw with wa≠0, and the ID instruction reads that register. Reads are defined as:
  - rs for add, addi, lw, sw, beq.
  - rt for add, sw, beq.
  - j never stalls.
- On stall: pc_we=0, ifid_we=0, ID/EX control loads bubble. EX/MEM and MEM/WB advance normally.
- Control transfer (ID):
  - j gives npc_sel=2, ifid_flush=1.
  - beq with beq_eq and no stall gives npc_sel=1, ifid_flush=1.
  - beq while stalled gives npc_sel=0, no flush; it re-evaluates next cycle.
  - Otherwise npc_sel=0, ifid_flush=0.
- Stage registers: ID/EX→EX/MEM→MEM/WB advance only when pipe_en=1. ex_* comes from ID/EX, mem_we from EX/MEM, wb_* from MEM/WB.
- Sequencer FSM states: HALT, RUN, STEP.
  - HALT: pipe_en=0. run=1 → RUN. step=1 (and run=0) → STEP.
  - RUN: pipe_en=1. run=0 → HALT.
  - STEP: pipe_en=1 for exactly one cycle → HALT (step ignored while in STEP).
  - run and step together in HALT: RUN wins.
- Freeze gating: when pipe_en=0, force mem_we=0, wb_rw=0, pc_we=0, ifid_we=0, ifid_flush=0, npc_sel=0. All state holds. This prevents repeated memory and register writes while halted.
- halted = (state==HALT).
- retired increments by 1 when pipe_en=1 and MEM/WB valid=1. Wraps modulo 2^CNT_W.
- Reset (rst=1 at edge):
  - State goes to HALT.
  - All stage control registers go to bubble.
  - retired=0.
  - After reset: pipe_en=0, stall=0, all enables/writes 0.
  - Reset mid-stall or mid-step discards the pending operation.
- Latency: decode and stall are combinational in ID. A control bit reaches EX +1 cycle, MEM +2, WB +3 after the instruction leaves ID.

Test Plan:
- Reset, run=1, stream addi $1,$0,5; add $2,$1,$1 → no stall; wb_rw=1 with wb_m2r=0 at cycles 4 and 5; retired=2 after the bubbles drain.
- lw $3,0($0) then add $4,$3,$3 → stall=1 for exactly 1 cycle with pc_we=ifid_we=0; a bubble enters EX; add reaches WB one cycle later than the unstalled case.
- lw $3 then beq $3,$0,+2 with beq_eq=1 → cycle 1: stall=1, npc_sel=0; cycle 2: npc_sel=1, ifid_flush=1.
- j 0x10 in ID → npc_sel=2, ifid_flush=1 in the same cycle; the following IF/ID word is nop and does not count toward retired.
- lw $0,0($0) then add $5,$0,$0 → no stall; wb_rw=0 for the lw.
- run=0, sw in EX/MEM, hold 5 cycles → mem_we=0 throughout, retired constant; one step pulse → exactly one cycle with pipe_en=1 and mem_we=1, then halted=1.
